// File: rtl/hmmm_core.sv
// rtl/hmmm_core.sv - multi-cycle HMMM core: FETCH/EXEC/MEM/HALT over one shared memory port
module hmmm_core #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halted,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t        state, state_nx;
    logic [15:0]   ir;
    logic [DW-1:0] regs [16];
    logic [AW-1:0] pc_q, pc_nx;
    logic          ir_ld;
    logic          rf_we;
    logic [DW-1:0] rf_wd;

    logic [3:0]    op, rx, ry, rz;
    logic [7:0]    imm8;
    logic [DW-1:0] vx, vy, vz, simm;
    logic [AW-1:0] imm_adr;
    logic          req_c, we_c;

    assign op      = ir[15:12];
    assign rx      = ir[11:8];
    assign ry      = ir[7:4];
    assign rz      = ir[3:0];
    assign imm8    = ir[7:0];
    // r0 is never written and resets to zero, so a plain read returns 0
    assign vx      = regs[rx];
    assign vy      = regs[ry];
    assign vz      = regs[rz];
    assign simm    = {{(DW-8){imm8[7]}}, imm8};
    assign imm_adr = AW'(imm8);

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        ir_ld    = 1'b0;
        rf_we    = 1'b0;
        rf_wd    = '0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        mem_adr  = pc_q;
        case (state)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_ld    = 1'b1;
                    pc_nx    = pc_q + AW'(1);
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = FETCH;
                case (op)
                    4'h0: state_nx = HALT;
                    4'h1: begin rf_we = 1'b1; rf_wd = simm;      end
                    4'h2: begin rf_we = 1'b1; rf_wd = vx + simm; end
                    4'h3: begin rf_we = 1'b1; rf_wd = vy;        end
                    4'h4: begin rf_we = 1'b1; rf_wd = vy + vz;   end
                    4'h5: begin rf_we = 1'b1; rf_wd = vy - vz;   end
                    4'h6, 4'h7, 4'h8, 4'h9: state_nx = MEM;
                    4'hA: pc_nx = imm_adr;
                    4'hB: if (vx == '0) pc_nx = imm_adr;
                    4'hC: if (vx != '0) pc_nx = imm_adr;
                    4'hD: if (!vx[DW-1] && vx != '0) pc_nx = imm_adr;
                    4'hE: if (vx[DW-1]) pc_nx = imm_adr;
                    default: pc_nx = vx[AW-1:0];
                endcase
            end
            MEM: begin
                // op[3] selects register-indirect (8/9) vs immediate (6/7); op[0] marks stores
                req_c   = 1'b1;
                we_c    = op[0];
                mem_adr = op[3] ? vy[AW-1:0] : imm_adr;
                if (mem_ready) begin
                    state_nx = FETCH;
                    if (!op[0]) begin
                        rf_we = 1'b1;
                        rf_wd = mem_rdata;
                    end
                end
            end
            default: state_nx = HALT;
        endcase
    end

    // reset drops the request combinationally so a pending transaction is abandoned at once
    assign mem_req   = req_c & ~reset;
    assign mem_we    = we_c & ~reset;
    assign mem_wdata = vx;
    assign halted    = (state == HALT);
    assign pc        = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc_q  <= '0;
            ir    <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            if (ir_ld) ir <= mem_rdata[15:0];
            if (rf_we && rx != 4'd0) regs[rx] <= rf_wd;
        end
    end

endmodule

// File: tb/tb_hmmm_core.sv
// tb/tb_hmmm_core.sv - directed self-checking bench for hmmm_core with a behavioural memory
module tb_hmmm_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted;
    logic [7:0]  mem_adr, pc;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;

    logic [15:0] mem [256];
    int          wr_count = 0;
    int          total = 0;
    int          bad = 0;

    hmmm_core #(.DW(16), .AW(8)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr];

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_adr] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [7:0]  bval [3];
        logic [15:0] bexp [3];
        int          n;

        // basic program, exact cycle count
        start();
        mem[0] = 16'h1105; mem[1] = 16'h12FD; mem[2] = 16'h4312; mem[3] = 16'h0000;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd0);
        release_reset();
        check("first_fetch_req", {31'd0, mem_req}, 32'd1);
        check("first_fetch_adr", {24'd0, mem_adr}, 32'd0);
        repeat (7) tick();
        check("not_halted_7", {31'd0, halted}, 32'd0);
        tick();
        check("halted_8", {31'd0, halted}, 32'd1);
        check("halt_pc", {24'd0, pc}, 32'd4);
        check("halt_no_req", {31'd0, mem_req}, 32'd0);
        repeat (5) tick();
        check("halt_absorbing", {31'd0, halted}, 32'd1);

        // same arithmetic, result stored to observe r3
        start();
        mem[0] = 16'h1105; mem[1] = 16'h12FD; mem[2] = 16'h4312;
        mem[3] = 16'h7380; mem[4] = 16'h0000; mem[8'h80] = 16'hAAAA;
        release_reset();
        run_halt("add_halt", 40);
        check("add_r3", {16'd0, mem[8'h80]}, 32'd2);

        // store held off by three wait cycles
        start();
        mem[0] = 16'h6140; mem[1] = 16'h7120; mem[2] = 16'h0000; mem[8'h40] = 16'h1234;
        release_reset();
        repeat (5) tick();
        wr_count = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("st_req", {31'd0, mem_req}, 32'd1);
            check("st_we", {31'd0, mem_we}, 32'd1);
            check("st_adr", {24'd0, mem_adr}, 32'h20);
            check("st_wdata", {16'd0, mem_wdata}, 32'h1234);
            tick();
        end
        mem_ready = 1'b1;
        run_halt("st_halt", 20);
        check("st_one_write", wr_count, 32'd1);
        check("st_mem", {16'd0, mem[8'h20]}, 32'h1234);

        // r0 stays zero
        start();
        mem[0] = 16'h1007; mem[1] = 16'h3400; mem[2] = 16'h7481; mem[3] = 16'h0000;
        mem[8'h81] = 16'hAAAA;
        release_reset();
        run_halt("r0_halt", 40);
        check("r0_copy", {16'd0, mem[8'h81]}, 32'd0);

        // conditional branches; r6 accumulates a bit per branch NOT taken
        bval[0] = 8'hFF; bexp[0] = 16'd5;
        bval[1] = 8'h00; bexp[1] = 16'd14;
        bval[2] = 8'h01; bexp[2] = 16'd9;
        for (int k = 0; k < 3; k++) begin
            start();
            mem[0] = {8'h11, bval[k]};
            mem[1] = 16'hB103; mem[2] = 16'h2601;
            mem[3] = 16'hC105; mem[4] = 16'h2602;
            mem[5] = 16'hD107; mem[6] = 16'h2604;
            mem[7] = 16'hE109; mem[8] = 16'h2608;
            mem[9] = 16'h7690; mem[10] = 16'h0000;
            release_reset();
            run_halt("br_halt", 80);
            check($sformatf("br_mask_v%0d", k), {16'd0, mem[8'h90]}, {16'd0, bexp[k]});
        end

        // jumpr with r5=0x1FF truncates to 0xFF; fetch there wraps pc to 0
        start();
        mem[0] = 16'h157F; mem[1] = 16'h4555; mem[2] = 16'h2501;
        mem[3] = 16'h4555; mem[4] = 16'h2501; mem[5] = 16'hF500;
        mem[8'hFF] = 16'h0000; mem[6] = 16'h1E01;
        release_reset();
        n = 0;
        while (!(mem_req && !mem_we && mem_adr == 8'hFF) && n < 40) begin
            tick();
            n++;
        end
        check("jumpr_pc", {24'd0, pc}, 32'hFF);
        run_halt("jumpr_halt", 10);
        check("pc_wrap", {24'd0, pc}, 32'h00);

        // addn wraps modulo 2^16
        start();
        mem[0] = 16'h11FF; mem[1] = 16'h2101; mem[2] = 16'h7192; mem[3] = 16'h0000;
        mem[8'h92] = 16'h5555;
        release_reset();
        run_halt("wrap_halt", 40);
        check("addn_wrap", {16'd0, mem[8'h92]}, 32'd0);

        // reset in the middle of a stalled loadr
        start();
        mem[0] = 16'h1250; mem[1] = 16'h1309; mem[2] = 16'h8320;
        mem[3] = 16'h7395; mem[4] = 16'h0000; mem[8'h50] = 16'h7777;
        release_reset();
        repeat (6) tick();
        mem_ready = 1'b0;
        #1;
        check("ld_req", {31'd0, mem_req}, 32'd1);
        check("ld_we", {31'd0, mem_we}, 32'd0);
        check("ld_adr", {24'd0, mem_adr}, 32'h50);
        tick();
        wr_count = 0;
        reset = 1'b1;
        #1;
        check("ld_rst_req_drop", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b1;
        tick();
        check("ld_rst_pc", {24'd0, pc}, 32'd0);
        check("ld_rst_halted", {31'd0, halted}, 32'd0);
        check("ld_rst_no_write", wr_count, 32'd0);
        release_reset();
        check("ld_restart_adr", {24'd0, mem_adr}, 32'd0);
        check("ld_restart_req", {31'd0, mem_req}, 32'd1);
        run_halt("ld_halt", 40);
        check("ld_value", {16'd0, mem[8'h95]}, 32'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hmmm_core.md
HMMM_CORE -- requirements
Module: hmmm_core

Interface
REQ-001 SHALL have parameter DW, default 16: data and register width, legal range 16..32.
REQ-002 SHALL have parameter AW, default 8: address and PC width, legal range 8..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port mem_req, output, 1: memory transaction request.
REQ-006 SHALL have port mem_we, output, 1: 1 = write, 0 = read; valid while mem_req=1.
REQ-007 SHALL have port mem_adr, output, AW: word address.
REQ-008 SHALL have port mem_wdata, output, DW: store data.
REQ-009 SHALL have port mem_rdata, input, DW: read data; sampled only when mem_req=1 and mem_ready=1.
REQ-010 SHALL have port mem_ready, input, 1: memory completes the transaction this cycle.
REQ-011 SHALL have port halted, output, 1: core is in HALT.
REQ-012 SHALL have port pc, output, AW: current PC (debug).

Function
REQ-013 Instruction SHALL be mem_rdata[15:0]: op=[15:12], rX=[11:8], rY=[7:4], rZ=[3:0], imm8=[7:0].
REQ-014 SHALL contain 16 registers of DW bits; r0 SHALL read 0 and writes to r0 SHALL be discarded.
REQ-015 Opcodes SHALL be: 0 halt; 1 setn rX=sext(imm8); 2 addn rX+=sext(imm8); 3 copy rX=rY; 4 add rX=rY+rZ; 5 sub rX=rY-rZ; 6 loadn rX=M[imm8]; 7 storen M[imm8]=rX; 8 loadr rX=M[rY]; 9 storer M[rY]=rX; A jumpn; B jeqzn; C jnezn; D jgtzn; E jltzn (condition on rX, signed, target imm8); F jumpr PC=rX.
REQ-016 Arithmetic SHALL wrap modulo 2^DW; no flags, no exceptions.
REQ-017 Address operands SHALL be imm8 zero-extended to AW, or the register value truncated to its low AW bits.
REQ-018 FSM states SHALL be FETCH, EXEC, MEM, HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_adr=pc; on mem_ready the instruction SHALL be latched, PC <= PC+1 (wrapping 2^AW-1 -> 0), then go to EXEC; otherwise stay in FETCH.
REQ-020 EXEC: ops 1-5 SHALL write rX and go to FETCH; ops A-F SHALL load PC with the target if taken and go to FETCH; ops 6-9 SHALL go to MEM; op 0 SHALL go to HALT.
REQ-021 MEM: mem_req=1, mem_we=1 for stores, mem_wdata=rX; on mem_ready loads SHALL write mem_rdata to rX, then go to FETCH; otherwise stay in MEM.
REQ-022 mem_adr, mem_we and mem_wdata SHALL be held stable while mem_req=1 and mem_ready=0.
REQ-023 mem_req SHALL be 0 in EXEC and HALT; mem_wdata SHALL be don't-care when mem_we=0.
REQ-024 With mem_ready tied to 1, latency SHALL be 2 cycles per non-memory instruction and 3 cycles per load/store.
REQ-025 HALT SHALL be absorbing; only reset exits it; halted=1 only in HALT.
REQ-026 A branch target register read and a write to the same register SHALL never coincide, since only one instruction is in flight.
REQ-027 Any mem_ready pulse while mem_req=0 SHALL be ignored.

Reset
REQ-028 While reset=1: state=FETCH, PC=0, all registers=0, instruction register=0, mem_req=0, mem_we=0, halted=0.
REQ-029 The first FETCH request SHALL appear in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-transaction SHALL immediately drop mem_req and discard the pending result; no register or PC update SHALL occur.

Verification
REQ-031 Zero-wait memory; program setn r1,5; setn r2,-3; add r3,r1,r2; halt -> r3=2, halted=1 after exactly 8 cycles, pc=4.
REQ-032 mem_ready held low 3 cycles on a storen r1,0x20 with r1=0x1234 -> mem_adr=0x20, mem_we=1, mem_wdata=0x1234 stable all 4 cycles; exactly one write occurs.
REQ-033 setn r0,7; copy r4,r0 -> r4=0.
REQ-034 Branches with r1 in {-1,0,1} -> jeqzn taken only for 0, jnezn for -1/1, jgtzn for 1, jltzn for -1; jumpr with r5=0x1FF and AW=8 -> pc=0xFF.
REQ-035 Wrap cases: addn r1,1 with r1=0xFFFF -> 0; fetch at pc=0xFF -> pc=0x00.
REQ-036 Reset asserted during a loadr with mem_ready=0 -> mem_req=0 immediately, destination register unchanged, execution restarts from pc=0.
